// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: WIDTH-bit unsigned binary to packed BCD digits.
// One adjust+shift step per clock; the result is held on BCD between conversions.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int SW = WIDTH + 4*DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]          r_state;
    logic [SW-1:0]       r_shift;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_done;

    logic [SW-1:0]       w_adj;
    logic [SW-1:0]       w_next;

    // Add-3 correction on each digit nibble only; the binary field below is untouched.
    always_comb begin
        w_adj = r_shift;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_shift[WIDTH + 4*d +: 4] >= 4'd5)
                w_adj[WIDTH + 4*d +: 4] = r_shift[WIDTH + 4*d +: 4] + 4'd3;
        end
        w_next = {w_adj[SW-2:0], 1'b0};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_shift <= {{(4*DIGITS){1'b0}}, Bin};
                        r_cnt   <= CW'(WIDTH);
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_next;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_bcd   <= w_next[SW-1:WIDTH];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy = (r_state == S_CONV);
    assign Done = r_done;
    assign BCD  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected digits and completion cycle,
// a negedge monitor checks Done timing, BCD value/stability and Busy every cycle.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 Start;
    logic [WIDTH-1:0]     Bin;
    logic                 Busy;
    logic                 Done;
    logic [4*DIGITS-1:0]  BCD;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Bin   (Bin),
        .Busy  (Busy),
        .Done  (Done),
        .BCD   (BCD)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4*DIGITS-1:0] e;
        int                  d;
    } exp_t;

    exp_t                exp_q[$];
    int                  cyc = 0;
    logic                rst_q = 1'b0;
    int                  n_tests = 0;
    int                  n_fail = 0;
    logic [4*DIGITS-1:0] hold = '0;
    logic                exp_done;
    logic                exp_busy;

    always @(posedge Clk) begin
        cyc   <= cyc + 1;
        rst_q <= Reset;
    end

    // Monitor: expectations follow from the queue; a reset edge flushes them.
    always @(negedge Clk) begin
        if (cyc > 0) begin
            if (rst_q) begin
                exp_q.delete();
                hold = '0;
                n_tests++;
                if (Busy !== 1'b0 || Done !== 1'b0 || BCD !== '0) begin
                    n_fail++;
                    $display("FAIL reset cyc=%0d: Busy=%b Done=%b BCD=%h, required 0 0 00000",
                             cyc, Busy, Done, BCD);
                end
            end else begin
                exp_done = (exp_q.size() > 0) && (exp_q[0].d == cyc);
                n_tests++;
                if (Done !== exp_done) begin
                    n_fail++;
                    $display("FAIL done_timing cyc=%0d: Done=%b, required %b", cyc, Done, exp_done);
                end
                if (exp_done) begin
                    hold = exp_q[0].e;
                    exp_q.pop_front();
                end
                n_tests++;
                if (BCD !== hold) begin
                    n_fail++;
                    $display("FAIL bcd cyc=%0d: BCD=%h, required %h", cyc, BCD, hold);
                end
                exp_busy = (exp_q.size() > 0);
                n_tests++;
                if (Busy !== exp_busy) begin
                    n_fail++;
                    $display("FAIL busy cyc=%0d: Busy=%b, required %b", cyc, Busy, exp_busy);
                end
            end
        end
    end

    // Called at #1 after an edge while the DUT is idle; the accepting edge is the next one.
    task automatic start_conv(input logic [WIDTH-1:0] b, input logic [4*DIGITS-1:0] e);
        Start = 1'b1;
        Bin   = b;
        @(posedge Clk);
        #1;
        exp_q.push_back('{e: e, d: cyc + WIDTH});
        Start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3*WIDTH; i++) begin
            @(posedge Clk);
            #1;
            if (Done) break;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    logic [WIDTH-1:0]    vin  [5];
    logic [4*DIGITS-1:0] vexp [5];

    initial begin
        vin[0] = 16'd1234;  vexp[0] = 20'h01234;
        vin[1] = 16'd0;     vexp[1] = 20'h00000;
        vin[2] = 16'd65535; vexp[2] = 20'h65535;
        vin[3] = 16'd9999;  vexp[3] = 20'h09999;
        vin[4] = 16'd10000; vexp[4] = 20'h10000;

        // Reset overrides a pending Start.
        Reset = 1'b1;
        Start = 1'b1;
        Bin   = 16'd1234;
        idle(2);
        Reset = 1'b0;
        Start = 1'b0;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            start_conv(vin[i], vexp[i]);
            wait_done();
            idle(1);
        end

        // Second Start mid-conversion is ignored.
        start_conv(16'd42, 20'h00042);
        idle(4);
        Start = 1'b1;
        Bin   = 16'd777;
        idle(1);
        Start = 1'b0;
        wait_done();
        idle(WIDTH + 4);

        // Start held high: next conversion accepted in the Done cycle.
        Start = 1'b1;
        Bin   = 16'd100;
        idle(1);
        exp_q.push_back('{e: 20'h00100, d: cyc + WIDTH});
        wait_done();
        Bin = 16'd200;
        idle(1);
        exp_q.push_back('{e: 20'h00200, d: cyc + WIDTH});
        wait_done();
        Start = 1'b0;
        idle(3);

        // Reset mid-conversion aborts; Start right after deassertion is accepted.
        start_conv(16'd5555, 20'h05555);
        idle(7);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        start_conv(16'd31, 20'h00031);
        wait_done();
        idle(WIDTH + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
